// File: rtl/rom_led_player.sv
// ROM-driven LED pattern sequencer: steps a ROM address at a fixed rate and
// registers the returned pattern onto the LEDs (loop, one-shot, ping-pong).
module rom_led_player #(
  parameter int LED_W    = 4,
  parameter int ADDR_W   = 14,
  parameter int DEPTH    = 16384,
  parameter int STEP_CYC = 100000,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk_1m,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [LED_W-1:0]  rom_q,
  output logic [LED_W-1:0]  led,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W     = $clog2(STEP_CYC);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [1:0]        MODE_ONESHOT  = 2'd1;
  localparam logic [1:0]        MODE_PINGPONG = 2'd2;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {UP, DOWN} dir_t;

  state_t             state;
  dir_t               dir;
  logic [CNT_W-1:0]   step_cnt;
  logic [ROM_LAT:0]   load_pipe;
  logic               tick;
  logic               finish;
  logic               addr_wr;

  assign tick    = (state == RUN) && !pause && (step_cnt == STEP_LAST);
  assign finish  = tick && (mode == MODE_ONESHOT) && (rom_addr == LAST);
  assign addr_wr = start || (tick && !finish);

  // Playback FSM; start takes priority over pause, ticks and completion.
  always_ff @(posedge clk_1m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      dir      <= UP;
      step_cnt <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state    <= RUN;
        busy     <= 1'b1;
        rom_addr <= '0;
        step_cnt <= '0;
        dir      <= UP;
      end else if (state == RUN && !pause) begin
        if (tick) begin
          step_cnt <= '0;
          case (mode)
            MODE_ONESHOT: begin
              dir <= UP;
              if (rom_addr == LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                rom_addr <= rom_addr + ADDR_W'(1);
              end
            end
            MODE_PINGPONG: begin
              // A single-entry ROM has no second address to bounce to.
              if (dir == UP) begin
                if (rom_addr == LAST) begin
                  if (LAST != '0) begin
                    dir      <= DOWN;
                    rom_addr <= rom_addr - ADDR_W'(1);
                  end
                end else begin
                  rom_addr <= rom_addr + ADDR_W'(1);
                end
              end else begin
                if (rom_addr == '0) begin
                  dir      <= UP;
                  rom_addr <= (LAST == '0) ? '0 : ADDR_W'(1);
                end else begin
                  rom_addr <= rom_addr - ADDR_W'(1);
                end
              end
            end
            default: begin
              dir      <= UP;
              rom_addr <= (rom_addr == LAST) ? '0 : rom_addr + ADDR_W'(1);
            end
          endcase
        end else begin
          step_cnt <= step_cnt + CNT_W'(1);
        end
      end
    end
  end

  // One stage beyond ROM_LAT because rom_addr is itself registered.
  always_ff @(posedge clk_1m or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      load_pipe <= '0;
      led       <= '0;
    end else begin
      load_pipe <= {load_pipe[ROM_LAT-1:0], addr_wr};
      if (load_pipe[ROM_LAT]) led <= rom_q;
    end
  end

endmodule

// File: tb/tb_rom_led_player.sv
// Directed bench for rom_led_player with STEP_CYC=4, DEPTH=8, ROM_LAT=1 and a
// registered ROM holding rom[i] = i + 8.
module tb_rom_led_player;

  logic       clk_1m = 1'b0;
  logic       sys_rst_n;
  logic       start;
  logic       pause;
  logic [1:0] mode;
  logic [3:0] rom_addr;
  logic [3:0] rom_q = 4'd0;
  logic [3:0] led;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  rom_led_player #(
    .LED_W(4), .ADDR_W(4), .DEPTH(8), .STEP_CYC(4), .ROM_LAT(1)
  ) dut (
    .clk_1m(clk_1m), .sys_rst_n(sys_rst_n), .start(start), .pause(pause),
    .mode(mode), .rom_addr(rom_addr), .rom_q(rom_q), .led(led),
    .busy(busy), .done(done)
  );

  always #5 clk_1m = ~clk_1m;

  always @(posedge clk_1m) rom_q <= rom_addr + 4'd8;

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk_1m);
    start = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b1;
    start = 1'b0; pause = 1'b0; mode = 2'd0;
    #2 sys_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_1m);
      start = i[0]; pause = i[1]; mode = 2'(i);
      @(negedge clk_1m);
      vectors++;
      if ({led, rom_addr, busy, done} !== 10'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: led=%0d addr=%0d busy=%0b done=%0b, want all 0", i, led, rom_addr, busy, done);
      end
    end
    start = 1'b0; pause = 1'b0; mode = 2'd0;
    sys_rst_n = 1'b1;
    @(negedge clk_1m);
    vectors++;
    if ({busy, led} !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: busy=%0b led=%0d, want 0 0", busy, led);
    end
  endtask

  task automatic test_loop;
    logic [3:0] exp;
    pulse_start(2'd0);
    vectors++;
    if ({busy, rom_addr} !== 5'b1_0000) begin
      miscompares++;
      $display("[TB] FAIL loop_entry: busy=%0b addr=%0d, want 1 0", busy, rom_addr);
    end
    @(negedge clk_1m);
    vectors++;
    if (led !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL loop_latency: led=%0d, want 0", led);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_1m);
      exp = 4'(8 + (k % 8));
      vectors++;
      if (led !== exp || rom_addr !== 4'(k % 8)) begin
        miscompares++;
        $display("[TB] FAIL loop_step[%0d]: led=%0d addr=%0d, want %0d %0d", k, led, rom_addr, exp, k % 8);
      end
      repeat (3) @(negedge clk_1m);
    end
  endtask

  task automatic test_one_shot;
    pulse_start(2'd1);
    repeat (29) @(negedge clk_1m);
    vectors++;
    if (led !== 4'd14) begin
      miscompares++;
      $display("[TB] FAIL oneshot_led14: led=%0d, want 14", led);
    end
    @(negedge clk_1m);
    vectors++;
    if (led !== 4'd15 || rom_addr !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL oneshot_last: led=%0d addr=%0d, want 15 7", led, rom_addr);
    end
    @(negedge clk_1m);
    vectors++;
    if ({busy, done} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL oneshot_pre_done: busy=%0b done=%0b, want 1 0", busy, done);
    end
    @(negedge clk_1m);
    vectors++;
    if ({busy, done} !== 2'b01 || led !== 4'd15 || rom_addr !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL oneshot_done: busy=%0b done=%0b led=%0d addr=%0d, want 0 1 15 7", busy, done, led, rom_addr);
    end
    @(negedge clk_1m);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL oneshot_done_width: done=%0b, want 0", done);
    end
    repeat (6) @(negedge clk_1m);
    vectors++;
    if ({busy, led, rom_addr} !== {1'b0, 4'd15, 4'd7}) begin
      miscompares++;
      $display("[TB] FAIL oneshot_idle_hold: busy=%0b led=%0d addr=%0d, want 0 15 7", busy, led, rom_addr);
    end
  endtask

  task automatic test_ping_pong;
    int seq;
    logic [3:0] exp;
    pulse_start(2'd2);
    @(negedge clk_1m);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_1m);
      seq = (k <= 7) ? k : ((k <= 14) ? 14 - k : k - 14);
      exp = 4'(8 + seq);
      vectors++;
      if (led !== exp) begin
        miscompares++;
        $display("[TB] FAIL pingpong_step[%0d]: led=%0d, want %0d", k, led, exp);
      end
      repeat (3) @(negedge clk_1m);
    end
  endtask

  task automatic test_pause;
    pulse_start(2'd0);
    repeat (13) @(negedge clk_1m);
    vectors++;
    if (rom_addr !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL pause_setup: addr=%0d, want 3", rom_addr);
    end
    pause = 1'b1;
    repeat (10) @(negedge clk_1m);
    vectors++;
    if ({busy, rom_addr, led} !== {1'b1, 4'd3, 4'd11}) begin
      miscompares++;
      $display("[TB] FAIL pause_hold: busy=%0b addr=%0d led=%0d, want 1 3 11", busy, rom_addr, led);
    end
    pause = 1'b0;
    repeat (2) @(negedge clk_1m);
    vectors++;
    if (rom_addr !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL pause_resume_early: addr=%0d, want 3", rom_addr);
    end
    @(negedge clk_1m);
    vectors++;
    if (rom_addr !== 4'd4) begin
      miscompares++;
      $display("[TB] FAIL pause_resume_tick: addr=%0d, want 4", rom_addr);
    end
    repeat (2) @(negedge clk_1m);
    vectors++;
    if (led !== 4'd12) begin
      miscompares++;
      $display("[TB] FAIL pause_resume_led: led=%0d, want 12", led);
    end
  endtask

  task automatic test_restart;
    repeat (3) @(negedge clk_1m);
    vectors++;
    if (rom_addr !== 4'd5) begin
      miscompares++;
      $display("[TB] FAIL restart_setup: addr=%0d, want 5", rom_addr);
    end
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk_1m);
    start = 1'b0;
    vectors++;
    if ({rom_addr, busy, done} !== {4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL restart_addr: addr=%0d busy=%0b done=%0b, want 0 1 0", rom_addr, busy, done);
    end
    @(negedge clk_1m);
    vectors++;
    if (led !== 4'd13) begin
      miscompares++;
      $display("[TB] FAIL restart_led_old: led=%0d, want 13", led);
    end
    @(negedge clk_1m);
    vectors++;
    if (led !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL restart_led_new: led=%0d, want 8", led);
    end
    repeat (4) @(negedge clk_1m);
    vectors++;
    if (rom_addr !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_paused: addr=%0d, want 0", rom_addr);
    end
    pause = 1'b0;
  endtask

  task automatic test_start_vs_finish;
    pulse_start(2'd1);
    repeat (31) @(negedge clk_1m);
    vectors++;
    if (rom_addr !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL svf_setup: addr=%0d, want 7", rom_addr);
    end
    start = 1'b1;
    @(negedge clk_1m);
    start = 1'b0;
    vectors++;
    if ({done, busy, rom_addr} !== {1'b0, 1'b1, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL svf_start_wins: done=%0b busy=%0b addr=%0d, want 0 1 0", done, busy, rom_addr);
    end
    @(negedge clk_1m);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL svf_no_done: done=%0b, want 0", done);
    end
  endtask

  task automatic test_reset_mid_run;
    pulse_start(2'd0);
    repeat (9) @(negedge clk_1m);
    vectors++;
    if ({busy, rom_addr, led} !== {1'b1, 4'd2, 4'd9}) begin
      miscompares++;
      $display("[TB] FAIL midrst_setup: busy=%0b addr=%0d led=%0d, want 1 2 9", busy, rom_addr, led);
    end
    sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({led, rom_addr, busy, done} !== 10'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: led=%0d addr=%0d busy=%0b done=%0b, want all 0", led, rom_addr, busy, done);
    end
    @(negedge clk_1m);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge clk_1m);
    vectors++;
    if ({led, rom_addr, busy} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_idle: led=%0d addr=%0d busy=%0b, want all 0", led, rom_addr, busy);
    end
  endtask

  initial begin
    test_reset();
    test_loop();
    test_one_shot();
    test_ping_pong();
    test_pause();
    test_restart();
    test_start_vs_finish();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
